// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream-to-memory loader.
// Optional readback check is enabled by defining MEM_LOADER_VERIFY_EN.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StVerify,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  localparam logic [31:0] ADDR_STEP      = 32'd4;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream, memory write/read port and status bundle of mem_loader.
// master = the loader, slave = byte source / memory / controller side.
interface mem_loader_if;

  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [15:0] word_count;
  logic        error;

  modport master (
    input  start, in_valid, in_data, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_rw, busy, done, word_count, error
  );

  modport slave (
    output start, in_valid, in_data, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_rw, busy, done, word_count, error
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: lane 0 lands in [7:0], lane 3 in [31:24].
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [7:0]        byte_i,
  output logic [31:0]       word_o
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clr_i) begin
      word_d = '0;
    end else if (we_i) begin
      for (int unsigned l = 0; l < BYTES_PER_WORD; l++) begin
        if (lane_i == LANE_W'(l)) begin
          word_d[8*l +: 8] = byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/mem_loader.sv
// Packs a byte stream into 32-bit words and writes them to consecutive addresses.
// Define MEM_LOADER_VERIFY_EN to read back and compare every written word.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Depth    = 256
) (
  input logic          clk_i,
  input logic          rst_ni,
  mem_loader_if.master bus_io
);

  localparam logic [15:0]       LastIdx  = 16'(Depth - 1);
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [15:0]         word_count_q, word_count_d;
  logic [31:0]         addr_q, addr_d;
  logic                accept, clr, advance;
  logic [31:0]         packed_word;

  assign accept = (state_q == StCollect) && bus_io.in_valid;

`ifdef MEM_LOADER_VERIFY_EN
  logic error_q, error_d, mismatch;
  // Readback data is valid in StCheck, one cycle after StVerify presented the address.
  assign mismatch = (state_q == StCheck) && (bus_io.mem_rdata != packed_word);
`endif

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    clr          = 1'b0;
    advance      = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
    error_d      = error_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          state_d      = StCollect;
          byte_idx_d   = '0;
          word_idx_d   = '0;
          word_count_d = '0;
          addr_d       = BaseAddr;
          clr          = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
          error_d      = 1'b0;
`endif
        end
      end
      StCollect: begin
        if (bus_io.in_valid) begin
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == LastLane) state_d = StWrite;
        end
      end
      StWrite: begin
`ifdef MEM_LOADER_VERIFY_EN
        state_d = StVerify;
`else
        advance = 1'b1;
`endif
      end
`ifdef MEM_LOADER_VERIFY_EN
      StVerify: state_d = StCheck;
      StCheck: begin
        if (mismatch) error_d = 1'b1;
        advance = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Word index holds at the last word so the address never runs past the load.
    if (advance) begin
      word_count_d = word_count_q + 16'd1;
      if (word_idx_q == LastIdx) begin
        state_d = StDone;
      end else begin
        state_d    = StCollect;
        word_idx_d = word_idx_q + 16'd1;
        addr_d     = addr_q + ADDR_STEP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      word_count_q <= '0;
      addr_q       <= BaseAddr;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bus_io.error = error_q | mismatch;
`else
  assign bus_io.error = 1'b0;
`endif

  byte_packer u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .we_i   (accept),
    .lane_i (byte_idx_q),
    .byte_i (bus_io.in_data),
    .word_o (packed_word)
  );

  assign bus_io.in_ready   = (state_q == StCollect);
  assign bus_io.mem_rw     = (state_q == StWrite) ? MEM_WR : MEM_RD;
  assign bus_io.busy       = (state_q == StCollect) || (state_q == StWrite) ||
                             (state_q == StVerify) || (state_q == StCheck);
  assign bus_io.done       = (state_q == StDone);
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_wdata  = packed_word;
  assign bus_io.word_count = word_count_q;

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream-to-memory writer: the write-side initiator for the team's synchronous 32-bit `memory` block. It accepts bytes over a valid/ready stream and packs them little-endian into 32-bit words. Each word is written to consecutive word addresses starting at `BASE_ADDR`, until `DEPTH` words are stored. It sits between a byte source (UART receiver, test stimulus) and the memory's write port, and fills program/data RAM before the read-side logic runs.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- `DEPTH`, 256, number of 32-bit words to write per load, ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load from `BASE_ADDR`; ignored while `busy`.
- `in_valid`  in  1  byte source has `in_data` valid.
- `in_data`  in  8  byte payload.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  32  byte address to memory.
- `mem_wdata`  out  32  write data to memory (`i_mem_data` on memory).
- `mem_rw`  out  1  1 = read, 0 = write; memory writes on the rising edge while 0.
- `mem_rdata`  in  32  memory read data (`o_mem_data`), valid 1 cycle after address.
- `busy`  out  1  load in progress.
- `done`  out  1  `DEPTH` words written; held until next `start`.
- `word_count`  out  16  words committed in the current load.
- `error`  out  1  sticky readback mismatch; constant 0 without `MEM_LOADER_VERIFY_EN`.

## Operation
- FSM states: IDLE, COLLECT, WRITE, VERIFY, CHECK, DONE. VERIFY and CHECK exist only with the macro.
- IDLE/DONE: on `start`, go to COLLECT. Clear `word_idx`, `byte_idx`, `word_count`, `error` and `done`.
- COLLECT: `in_ready`=1. Each `in_valid & in_ready` byte goes to lane `byte_idx`: byte 0 → [7:0], byte 3 → [31:24]. `byte_idx` increments by one per byte. The 4th byte moves the FSM to WRITE.
- WRITE: exactly one cycle, with `mem_rw`=0, `mem_addr`=`BASE_ADDR`+4·`word_idx` and `mem_wdata`=packed word.
  - Without the macro, `word_idx` and `word_count` increment. The FSM goes to DONE if `word_idx`==`DEPTH`-1, otherwise to COLLECT.
- VERIFY: `mem_rw`=1 at the same address.
- CHECK: compare `mem_rdata` with the packed word; on mismatch set `error`. Then do the same increment and exit as WRITE without the macro.
- Outside WRITE, `mem_rw`=1. The block never issues a spurious write.
- `in_ready`, `mem_rw`, `busy` and `done` are decoded from registered state only. There is no combinational path from `in_valid` to `in_ready`.
- Address arithmetic is 32-bit and wraps silently. `word_idx` never exceeds `DEPTH`-1.
- Reset mid-load: return to IDLE immediately. A partial word is discarded and no write is issued. Memory contents already written are kept.
- `start` during COLLECT/WRITE/VERIFY/CHECK is ignored. `start` in DONE restarts the load.

## Timing
- Reset values: `in_ready`=0, `mem_rw`=1, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `start` at cycle N → `in_ready`=1 and `busy`=1 at N+1.
- 4th byte accepted at cycle M → write strobe (`mem_rw`=0) at M+1. `in_ready`=0 during M+1.
  - Without the macro: `in_ready` returns at M+2.
  - With the macro: VERIFY at M+2, CHECK at M+3, `in_ready` returns at M+4.
- Peak throughput: 5 cycles/word, or 7 cycles/word with verify.
- `done` rises the cycle after the final write (or final CHECK), together with `busy` falling.

## Configuration
- `MEM_LOADER_VERIFY_EN` defined:
  - every write is followed by a readback and compare;
  - `error` is sticky until the next `start`.
- `MEM_LOADER_VERIFY_EN` undefined:
  - VERIFY and CHECK are absent;
  - `mem_rdata` is unused;
  - `error` is tied to 0.

## Structure
- Shared package `mem_loader_pkg`:
  - state encoding constants;
  - `BYTES_PER_WORD`=4;
  - `ADDR_STEP`=4;
  - `MEM_RD`=1'b1 and `MEM_WR`=1'b0.
- One sub-module, `byte_packer`:
  - inputs: byte lane index, byte, write enable and clear;
  - output: the 32-bit assembled word.
- The FSM, address counter and verify compare stay in `mem_loader`.

## Test plan
- Reset, then `start`, `DEPTH`=4, bytes 00..0F streamed with `in_valid` held high.
  - Required: writes of 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at 0x0, 0x4, 0x8, 0xC.
  - Required: `done`=1 and `word_count`=4.
- Byte source toggles `in_valid` every other cycle.
  - Required: identical memory contents.
  - Required: no write while fewer than 4 bytes have been accepted.
- Assert `resetn` low after 2 bytes of word 1.
  - Required: all outputs take their reset values asynchronously.
  - Required: no write strobe; word 0 remains in memory.
- `start` pulsed while `busy`.
  - Required: ignored; `word_count` and `mem_addr` sequence unchanged.
- With `MEM_LOADER_VERIFY_EN`, force `mem_rdata` bit 0 flipped on word 2.
  - Required: `error`=1 from that CHECK cycle until the next `start`; load still completes.
- `BASE_ADDR`=32'hFFFF_FFF8, `DEPTH`=4.
  - Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
